uart_rx_fifo: RTL and testbench

- Oversampling UART receiver with integrated receive buffer; the receive-side counterpart of the link's UART transmitter.
- Recovers 8N1 (optional parity) frames from the asynchronous rx pin and stores bytes in a FIFO.
- Presents bytes on a valid/ready stream to the link logic.
- Reports framing, parity, overrun and break conditions as single-cycle pulses.

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/uart_sync_fifo.sv | 59 +++++
 rtl/uart_rx_fifo.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and elaboration helpers for the oversampling UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } rx_state_t;

    // Clocks per oversample tick; never below one so the divider always advances.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        int unsigned d;
        d = clk_freq / (baud_rate * oversample);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO; a pop frees room for a same-cycle push when full.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    output logic                   full,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign count   = count_q;

    // Masked so the output reads zero whenever nothing is held.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling 8N1/parity UART receiver feeding a FWFT byte FIFO on a valid/ready stream.
// Line errors are reported as single-cycle pulses aligned to the stop-bit decision.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ena,
    input  logic                        rx,
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overrun,
    output logic                        break_det
);

    localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SmpW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW = $clog2(DATA_WIDTH);
    localparam int unsigned SmpA = OVERSAMPLE / 2 - 1;
    localparam int unsigned SmpB = OVERSAMPLE / 2;
    localparam int unsigned SmpC = OVERSAMPLE / 2 + 1;
    localparam bit          ParEn  = (PARITY_EN != 0);
    localparam logic        ParOdd = (PARITY_ODD != 0);

    logic                  rx_meta_q, rx_s_q, rx_prev_q;
    logic [DivW-1:0]       div_cnt_q, div_cnt_d;
    logic [SmpW-1:0]       smp_cnt_q, smp_cnt_d;
    logic                  s0_q, s1_q;
    rx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  par_err_q, par_err_d;
    logic                  push_q, push_d;
    logic                  frame_err_q, frame_err_d;
    logic                  parity_err_q, parity_err_d;
    logic                  break_q, break_d;
    logic                  overrun_q;
    logic                  tick, decide, bit_val, fall;
    logic                  fifo_full, fifo_empty;

    assign tick    = ena && (div_cnt_q == DivW'(DIV - 1));
    assign decide  = tick && (smp_cnt_q == SmpW'(SmpC));
    assign bit_val = majority3(s0_q, s1_q, rx_s_q);
    assign fall    = rx_prev_q & ~rx_s_q;

    always_comb begin
        div_cnt_d    = div_cnt_q;
        smp_cnt_d    = smp_cnt_q;
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        par_err_d    = par_err_q;
        push_d       = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        break_d      = 1'b0;
        if (!ena) begin
            div_cnt_d = '0;
            smp_cnt_d = '0;
            state_d   = StIdle;
        end else begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
            if (tick) begin
                smp_cnt_d = (smp_cnt_q == SmpW'(OVERSAMPLE - 1)) ? '0 : smp_cnt_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (fall) begin
                        state_d   = StStart;
                        div_cnt_d = '0;
                        smp_cnt_d = '0;
                    end
                end
                StStart: begin
                    if (decide) begin
                        state_d   = bit_val ? StIdle : StData;
                        bit_cnt_d = '0;
                        par_err_d = 1'b0;
                    end
                end
                StData: begin
                    if (decide) begin
                        shift_d   = {bit_val, shift_q[DATA_WIDTH-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BitW'(DATA_WIDTH - 1)) begin
                            state_d = ParEn ? StParity : StStop;
                        end
                    end
                end
                StParity: begin
                    if (decide) begin
                        par_err_d = bit_val != ((^shift_q) ^ ParOdd);
                        state_d   = StStop;
                    end
                end
                StStop: begin
                    // Decided mid stop bit so a back-to-back start edge is not missed.
                    if (decide) begin
                        parity_err_d = par_err_q;
                        if (bit_val) begin
                            push_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            frame_err_d = 1'b1;
                            if (shift_q == '0) begin
                                break_d = 1'b1;
                                state_d = StBrkWait;
                            end else begin
                                state_d = StIdle;
                            end
                        end
                    end
                end
                StBrkWait: begin
                    if (rx_s_q) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            div_cnt_q    <= '0;
            smp_cnt_q    <= '0;
            s0_q         <= 1'b1;
            s1_q         <= 1'b1;
            state_q      <= StIdle;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            par_err_q    <= 1'b0;
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            break_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            rx_prev_q    <= rx_s_q;
            div_cnt_q    <= div_cnt_d;
            smp_cnt_q    <= smp_cnt_d;
            if (tick && smp_cnt_q == SmpW'(SmpA)) s0_q <= rx_s_q;
            if (tick && smp_cnt_q == SmpW'(SmpB)) s1_q <= rx_s_q;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            par_err_q    <= par_err_d;
            push_q       <= push_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            break_q      <= break_d;
            overrun_q    <= push_q & fifo_full & ~(m_ready & m_valid);
        end
    end

    // shift_q is untouched until the next frame's data bits, so it is still the byte here.
    uart_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (shift_q),
        .full      (fifo_full),
        .pop       (m_ready),
        .pop_data  (m_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m_valid    = ~fifo_empty;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign break_det  = break_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a plain 8N1 instance and an even-parity instance.
module tb_uart_rx_fifo;

    // Reduced clock keeps runtime short; DIV = 15e6/(115200*16) = 8 (truncated), bit = 130 clk.
    localparam int unsigned CLK_FREQ = 15_000_000;
    localparam int unsigned BAUD     = 115_200;
    localparam int          BIT_CLKS = 130;
    localparam int          TICK_CLKS = 8;

    logic       clk = 1'b0;
    logic       reset, ena, rx, rx_p, m_ready, m_ready_p;
    logic [7:0] m_data, m_data_p;
    logic       m_valid, m_valid_p;
    logic [3:0] fifo_count, fifo_count_p;
    logic       frame_err, parity_err, overrun, break_det;
    logic       frame_err_p, parity_err_p, overrun_p, break_det_p;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DATA_WIDTH (8),
        .BAUD_RATE  (BAUD),
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (8),
        .PARITY_EN  (0),
        .PARITY_ODD (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ena        (ena),
        .rx         (rx),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .break_det  (break_det)
    );

    uart_rx_fifo #(
        .DATA_WIDTH (8),
        .BAUD_RATE  (BAUD),
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (8),
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dut_p (
        .clk        (clk),
        .reset      (reset),
        .ena        (ena),
        .rx         (rx_p),
        .m_data     (m_data_p),
        .m_valid    (m_valid_p),
        .m_ready    (m_ready_p),
        .fifo_count (fifo_count_p),
        .frame_err  (frame_err_p),
        .parity_err (parity_err_p),
        .overrun    (overrun_p),
        .break_det  (break_det_p)
    );

    int unsigned n_checks = 0;
    int unsigned n_bad = 0;

    logic [7:0] got_q[$];
    logic [7:0] got_p_q[$];
    int unsigned n_valid, n_frame, n_par, n_ovr, n_brk, n_frame_p, n_par_p;

    always @(negedge clk) begin
        if (m_valid) n_valid = n_valid + 1;
        if (m_valid && m_ready) got_q.push_back(m_data);
        if (m_valid_p && m_ready_p) got_p_q.push_back(m_data_p);
        if (frame_err) n_frame = n_frame + 1;
        if (parity_err) n_par = n_par + 1;
        if (overrun) n_ovr = n_ovr + 1;
        if (break_det) n_brk = n_brk + 1;
        if (frame_err_p) n_frame_p = n_frame_p + 1;
        if (parity_err_p) n_par_p = n_par_p + 1;
    end

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        got_p_q.delete();
        n_valid = 0; n_frame = 0; n_par = 0; n_ovr = 0; n_brk = 0;
        n_frame_p = 0; n_par_p = 0;
    endtask

    function automatic int unsigned got_at(input int i);
        return (i < got_q.size()) ? int'(got_q[i]) : 32'hDEAD;
    endfunction

    function automatic int unsigned got_p_at(input int i);
        return (i < got_p_q.size()) ? int'(got_p_q[i]) : 32'hDEAD;
    endfunction

    task automatic hold_line(input bit which, input logic v, input int clks);
        if (which) rx_p = v;
        else rx = v;
        repeat (clks) @(negedge clk);
    endtask

    // Start, 8 data bits LSB first, optional parity, stop, then one idle bit.
    task automatic send_frame(input bit which, input logic [7:0] d, input logic stop_bit,
                              input bit has_par, input logic par_bit);
        hold_line(which, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold_line(which, d[i], BIT_CLKS);
        if (has_par) hold_line(which, par_bit, BIT_CLKS);
        hold_line(which, stop_bit, BIT_CLKS);
        hold_line(which, 1'b1, BIT_CLKS);
    endtask

    initial begin
        logic [7:0] c3;
        reset = 1'b1; ena = 1'b1; rx = 1'b1; rx_p = 1'b1;
        m_ready = 1'b1; m_ready_p = 1'b1;
        clear_mon();
        repeat (4) @(negedge clk);
        check_eq("rst m_valid", m_valid, 0);
        check_eq("rst m_data", m_data, 0);
        check_eq("rst count", fifo_count, 0);
        check_eq("rst pulses", {frame_err, parity_err, overrun, break_det}, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Two clean bytes, consumer always ready.
        clear_mon();
        send_frame(0, 8'h55, 1'b1, 0, 1'b0);
        send_frame(0, 8'hA3, 1'b1, 0, 1'b0);
        check_eq("t1 nbytes", got_q.size(), 2);
        check_eq("t1 byte0", got_at(0), 8'h55);
        check_eq("t1 byte1", got_at(1), 8'hA3);
        check_eq("t1 valid cycles", n_valid, 2);
        check_eq("t1 errs", n_frame + n_par + n_ovr + n_brk, 0);
        check_eq("t1 count", fifo_count, 0);

        // Fill with consumer stalled; ninth byte overruns.
        clear_mon();
        m_ready = 1'b0;
        for (int b = 0; b < 8; b++) send_frame(0, 8'(b), 1'b1, 0, 1'b0);
        check_eq("t2 count full", fifo_count, 8);
        check_eq("t2 ovr before", n_ovr, 0);
        send_frame(0, 8'h08, 1'b1, 0, 1'b0);
        check_eq("t2 ovr pulses", n_ovr, 1);
        check_eq("t2 count held", fifo_count, 8);
        check_eq("t2 head stable", m_data, 8'h00);
        m_ready = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("t2 drained n", got_q.size(), 8);
        for (int i = 0; i < 8; i++) check_eq("t2 drain order", got_at(i), i);
        check_eq("t2 count empty", fifo_count, 0);

        // Low stop bit on nonzero data.
        clear_mon();
        send_frame(0, 8'h3C, 1'b0, 0, 1'b0);
        check_eq("t3 frame_err", n_frame, 1);
        check_eq("t3 break", n_brk, 0);
        check_eq("t3 no push", got_q.size(), 0);
        check_eq("t3 count", fifo_count, 0);
        send_frame(0, 8'h3C, 1'b1, 0, 1'b0);
        check_eq("t3 recover n", got_q.size(), 1);
        check_eq("t3 recover byte", got_at(0), 8'h3C);
        check_eq("t3 frame_err once", n_frame, 1);

        // Line break for 12 bit times.
        clear_mon();
        hold_line(0, 1'b0, 12 * BIT_CLKS);
        check_eq("t4 break", n_brk, 1);
        check_eq("t4 frame_err", n_frame, 1);
        check_eq("t4 no push", got_q.size(), 0);
        hold_line(0, 1'b1, 2 * BIT_CLKS);
        check_eq("t4 break once", n_brk, 1);
        send_frame(0, 8'h7E, 1'b1, 0, 1'b0);
        check_eq("t4 after n", got_q.size(), 1);
        check_eq("t4 after byte", got_at(0), 8'h7E);

        // Three-tick glitch is a false start.
        clear_mon();
        hold_line(0, 1'b0, 3 * TICK_CLKS);
        hold_line(0, 1'b1, 2 * BIT_CLKS);
        check_eq("t5 glitch push", got_q.size(), 0);
        check_eq("t5 glitch errs", n_frame + n_par + n_ovr + n_brk, 0);

        // Even parity: 0x81 has even ones, so parity bit 1 is wrong, 0 is right.
        send_frame(1, 8'h81, 1'b1, 1, 1'b1);
        check_eq("t5 par n", got_p_q.size(), 1);
        check_eq("t5 par byte", got_p_at(0), 8'h81);
        check_eq("t5 par err", n_par_p, 1);
        check_eq("t5 par frame", n_frame_p, 0);
        send_frame(1, 8'h81, 1'b1, 1, 1'b0);
        check_eq("t5 par ok n", got_p_q.size(), 2);
        check_eq("t5 par ok err", n_par_p, 1);

        // Reset in the middle of data bit 4 with one byte already buffered.
        clear_mon();
        m_ready = 1'b0;
        send_frame(0, 8'h5A, 1'b1, 0, 1'b0);
        check_eq("t6 pre count", fifo_count, 1);
        c3 = 8'hC3;
        hold_line(0, 1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) hold_line(0, c3[i], BIT_CLKS);
        hold_line(0, c3[4], BIT_CLKS / 2);
        reset = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        check_eq("t6 rst m_valid", m_valid, 0);
        check_eq("t6 rst m_data", m_data, 0);
        check_eq("t6 rst count", fifo_count, 0);
        check_eq("t6 rst pulses", {frame_err, parity_err, overrun, break_det}, 0);
        reset = 1'b0;
        m_ready = 1'b1;
        hold_line(0, 1'b1, 2 * BIT_CLKS);
        check_eq("t6 nothing pushed", got_q.size(), 0);
        send_frame(0, 8'hC3, 1'b1, 0, 1'b0);
        check_eq("t6 after n", got_q.size(), 1);
        check_eq("t6 after byte", got_at(0), 8'hC3);
        check_eq("t6 errs", n_frame + n_par + n_ovr + n_brk, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
